// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: bus command encodings and arbiter state type shared by the
// memory arbiter and its starvation counter.
package mem_arbiter_pkg;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} arb_state_e;
endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: grant decision for the shared bus plus a saturating count
// of data grants taken while a fetch was waiting.
module mem_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic i_req_i,
    input  logic d_req_i,
    output logic gnt_d_o
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q, cnt_d;

    // Data wins unless fetch has already been passed over LIMIT times.
    assign gnt_d_o = d_req_i & ~(i_req_i & (cnt_q == LIMIT));

    always_comb begin
        cnt_d = !idle_i ? cnt_q :
                (i_req_i && gnt_d_o) ? ((cnt_q == LIMIT) ? cnt_q : cnt_q + 4'd1) :
                4'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 4'd0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between instruction fetch
// and data access, one transaction at a time, with stalls and done pulses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_cmd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic [1:0]        d_cmd,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    arb_state_e        state_q, state_d;
    logic              owner_q;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
    logic              i_req, d_req, idle, grant, gnt_d, busy;

    assign i_req = i_cmd != BUS_NONE;
    assign d_req = d_cmd != BUS_NONE;
    assign idle  = state_q == IDLE;
    assign grant = idle & (i_req | d_req);
    assign busy  = (state_q == I_BUSY) | (state_q == D_BUSY);

    mem_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .idle_i  (idle),
        .i_req_i (i_req),
        .d_req_i (d_req),
        .gnt_d_o (gnt_d)
    );

    always_comb begin
        state_d = idle ? (grant ? (gnt_d ? D_BUSY : I_BUSY) : IDLE) :
                  (state_q == DONE) ? IDLE :
                  mem_ack ? DONE : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            cmd_q     <= BUS_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= gnt_d;
                cmd_q   <= gnt_d ? d_cmd : BUS_LOAD;
                addr_q  <= gnt_d ? d_addr : i_addr;
                wdata_q <= gnt_d ? d_wdata : '0;
            end
            if (state_q == I_BUSY && mem_ack) i_rdata_q <= mem_rdata;
            // Stores complete without disturbing the last load result.
            if (state_q == D_BUSY && mem_ack && cmd_q == BUS_LOAD) d_rdata_q <= mem_rdata;
        end
    end

    assign mem_cmd   = busy ? cmd_q : BUS_NONE;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = (state_q == DONE) & ~owner_q;
    assign d_done    = (state_q == DONE) & owner_q;
    assign i_stall   = i_req & ~i_done;
    assign d_stall   = d_req & ~d_done;
endmodule
